// File: rtl/gost89_pkg.sv
// rtl/gost89_pkg.sv - shared types, round count and key schedule for the GOST 28147-89 core
package gost89_pkg;

    typedef logic [63:0]  block_t;
    typedef logic [31:0]  half_t;
    typedef logic [255:0] key_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    localparam int ROUNDS = 32;

    // Encrypt walks K0..K7 three times then K7..K0; decrypt is the mirror image.
    // In both cases "7 - (r mod 8)" is simply the inverted low three bits.
    function automatic logic [2:0] key_index(input logic [4:0] round, input logic decrypt);
        if (!decrypt) begin
            return (round < 5'd24) ? round[2:0] : ~round[2:0];
        end
        return (round < 5'd8) ? round[2:0] : ~round[2:0];
    endfunction

endpackage

// File: rtl/gost89_round.sv
// rtl/gost89_round.sv - combinational GOST round: add key, substitute, rotate left 11, xor
module gost89_round
    import gost89_pkg::*;
(
    input  half_t        n1_i,
    input  half_t        n2_i,
    input  half_t        k_i,
    input  logic [511:0] sbox_i,
    output half_t        res_o
);

    half_t       t;
    half_t       sub;
    logic [63:0] box;

    always_comb begin
        t   = n1_i + k_i;
        sub = '0;
        box = '0;
        for (int i = 0; i < 8; i++) begin
            // S1 sits in the top 64 bits and serves nibble 0; entry 0 is the box's top nibble.
            box            = sbox_i[64*(7-i) +: 64];
            sub[4*i +: 4]  = box[{~t[4*i +: 4], 2'b00} +: 4];
        end
        res_o = {sub[20:0], sub[31:21]} ^ n2_i;
    end

endmodule

// File: rtl/gost89_ecb_core.sv
// rtl/gost89_ecb_core.sv - iterative GOST 28147-89 ECB core, one round per clock
module gost89_ecb_core
    import gost89_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         mode,
    input  logic         load_data,
    input  logic [511:0] sbox,
    input  logic [255:0] key,
    input  logic [63:0]  in,
    output logic [63:0]  out,
    output logic         busy
);

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    half_t      n1_q, n1_d;
    half_t      n2_q, n2_d;
    logic       mode_q, mode_d;
    block_t     out_q, out_d;

    logic [2:0] kidx;
    half_t      kr;
    half_t      round_res;

    assign kidx = key_index(cnt_q, mode_q);
    assign kr   = key[{~kidx, 5'b00000} +: 32];

    gost89_round u_round (
        .n1_i   (n1_q),
        .n2_i   (n2_q),
        .k_i    (kr),
        .sbox_i (sbox),
        .res_o  (round_res)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            n1_q    <= '0;
            n2_q    <= '0;
            mode_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n1_q    <= n1_d;
            n2_q    <= n2_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n1_d    = n1_q;
        n2_d    = n2_q;
        mode_d  = mode_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (load_data) begin
                    n1_d    = in[63:32];
                    n2_d    = in[31:0];
                    mode_d  = mode;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                n1_d  = round_res;
                n2_d  = n1_q;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(ROUNDS - 1)) begin
                    // Last round leaves N1 in place, so the swap is undone on the way out.
                    out_d   = {n1_q, round_res};
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out  = out_q;
    assign busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_gost89_ecb_core.sv
// tb/tb_gost89_ecb_core.sv - scoreboard bench for the GOST 28147-89 ECB core
module tb_gost89_ecb_core;

    logic         clk;
    logic         reset_n;
    logic         mode;
    logic         load_data;
    logic [511:0] sbox;
    logic [255:0] key;
    logic [63:0]  in_blk;
    logic [63:0]  out_blk;
    logic         busy;

    int vectors;
    int miscompares;
    logic [63:0] exp_q[$];

    gost89_ecb_core dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode),
        .load_data (load_data),
        .sbox      (sbox),
        .key       (key),
        .in        (in_blk),
        .out       (out_blk),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; the load edge is the following rising edge.
    task automatic start_block(input logic m, input logic [63:0] blk, input logic [63:0] expect_blk,
                               input bit push);
        mode      = m;
        in_blk    = blk;
        load_data = 1'b1;
        if (push) exp_q.push_back(expect_blk);
        @(negedge clk);
        load_data = 1'b0;
    endtask

    task automatic wait_done(output bit timed_out, output int cycles, output bit out_moved);
        logic [63:0] held;
        held      = out_blk;
        cycles    = 0;
        out_moved = 1'b0;
        timed_out = 1'b0;
        while (busy) begin
            if (out_blk !== held) out_moved = 1'b1;
            if (cycles >= 40) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        vectors++;
        if (out_blk !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_out: got %h want 0000000000000000", out_blk);
        end
    endtask

    task automatic test_encrypt_decrypt(input logic [63:0] pt, input logic [63:0] ct, input string tag);
        bit          tmo;
        int          cyc;
        bit          moved;
        logic [63:0] exp;
        for (int m = 0; m < 2; m++) begin
            start_block(m[0], m[0] ? ct : pt, m[0] ? pt : ct, 1'b1);
            wait_done(tmo, cyc, moved);
            exp = exp_q.pop_front();
            vectors++;
            if (tmo) begin
                miscompares++;
                $display("FAIL %s_timeout mode=%0d: busy still high after %0d cycles", tag, m, cyc);
            end
            vectors++;
            if (out_blk !== exp) begin
                miscompares++;
                $display("FAIL %s_out mode=%0d: got %h want %h", tag, m, out_blk, exp);
            end
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_busy mode=%0d: got %b want 0", tag, m, busy);
            end
        end
    endtask

    task automatic test_reset_pulse();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        test_encrypt_decrypt(64'h389eb44a391474c4, 64'h7aea1ed18e604249, "reset_pulse");
    endtask

    task automatic test_abort();
        start_block(1'b0, 64'h0123456789abcdef, 64'h0, 1'b0);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_busy: got %b want 0", busy);
        end
        vectors++;
        if (out_blk !== 64'h0) begin
            miscompares++;
            $display("FAIL abort_out: got %h want 0000000000000000", out_blk);
        end
        @(negedge clk);
        reset_n = 1'b1;
        test_encrypt_decrypt(64'h379e59c3c96bb2ab, 64'hc35472c91cd78640, "abort");
    endtask

    task automatic test_reset_vs_load();
        reset_n   = 1'b0;
        mode      = 1'b0;
        in_blk    = 64'hffffffffffffffff;
        load_data = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL same_edge_busy: got %b want 0", busy);
        end
        @(negedge clk);
        reset_n   = 1'b1;
        load_data = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL same_edge_busy_after: got %b want 0", busy);
        end
        test_encrypt_decrypt(64'h3f38ae3b8f541361, 64'h3b5834a000fba066, "same_edge");
    endtask

    task automatic test_load_while_busy();
        bit          tmo;
        int          cyc;
        bit          moved;
        logic [63:0] exp;
        start_block(1'b0, 64'hd5a8a608f4f115b4, 64'hd658a36b11cf46eb, 1'b1);
        repeat (9) @(negedge clk);
        start_block(1'b1, 64'h389eb44a391474c4, 64'h0, 1'b0);
        wait_done(tmo, cyc, moved);
        exp = exp_q.pop_front();
        vectors++;
        if (tmo || cyc != 32 - 10) begin
            miscompares++;
            $display("FAIL busy_load_cycles: got %0d remaining cycles want 22", cyc);
        end
        vectors++;
        if (out_blk !== exp) begin
            miscompares++;
            $display("FAIL busy_load_out: got %h want %h", out_blk, exp);
        end
    endtask

    task automatic test_busy_timing();
        bit          tmo;
        int          cyc;
        bit          moved;
        logic [63:0] exp;
        start_block(1'b1, 64'h7aea1ed18e604249, 64'h389eb44a391474c4, 1'b1);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_rise: got %b want 1", busy);
        end
        wait_done(tmo, cyc, moved);
        exp = exp_q.pop_front();
        vectors++;
        if (tmo || cyc != 32) begin
            miscompares++;
            $display("FAIL busy_width: got %0d cycles want 32", cyc);
        end
        vectors++;
        if (moved) begin
            miscompares++;
            $display("FAIL out_stable: got changed want unchanged while busy");
        end
        vectors++;
        if (out_blk !== exp) begin
            miscompares++;
            $display("FAIL timing_out: got %h want %h", out_blk, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        mode        = 1'b0;
        load_data   = 1'b0;
        in_blk      = '0;
        sbox = 512'h4a92d80e6b1c7f53eb4c6dfa23810759581da342efc7609b7da1089fe46cb2536c715fd84a9e03b24ba0721d36859cfedb413f590ae7682c1fd057a4923e6b8c;
        key  = 256'h0475f6e05038fbfad2c7c390edb3ca3d1547124291ae1e8a2f79cd9ed2bcefbd;
        repeat (2) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_encrypt_decrypt(64'hd5a8a608f4f115b4, 64'hd658a36b11cf46eb, "kat");
        test_reset_pulse();
        test_abort();
        test_reset_vs_load();
        test_load_while_busy();
        test_busy_timing();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
